// File: rtl/usr_pkg.sv
// usr_pkg: shared types for the universal shift register.
//   mode_t  : manual operating mode selected by the Mode port.
//   state_t : burst engine state.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Encoding of the burst direction bit (Dir port and latched copy).
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_burst_ctrl.sv
// usr_burst_ctrl: self-timed burst engine for the universal shift register.
// Accepts a Start request in IDLE, then commands one shift per clock for
// Count cycles in the direction latched at Start.
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   start_i      burst request (only looked at in IDLE)
//   dir_i        burst direction (0 right, 1 left), latched at Start
//   count_i      number of shifts, latched at Start
//   shift_en_o   datapath performs a burst shift on this edge
//   shift_dir_o  latched burst direction
//   manual_en_o  datapath may apply manual Mode on this edge
//   busy_o       burst in progress
//   done_o       one-cycle pulse after a burst (or zero-length request) ends
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             shift_en_o,
  output logic             shift_dir_o,
  output logic             manual_en_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [CNT_W-1:0] remaining_q;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      dir_q       <= DIR_RIGHT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (count_i != '0) begin
              dir_q       <= dir_i;
              remaining_q <= count_i;
              state_q     <= ST_SHIFT;
              busy_q      <= 1'b1;
            end else begin
              // Zero-length burst: report completion without shifting.
              done_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          remaining_q <= remaining_q - CNT_ONE;
          if (remaining_q == CNT_ONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign shift_en_o  = (state_q == ST_SHIFT);
  assign shift_dir_o = dir_q;
  // A Start edge in IDLE takes priority over manual operation.
  assign manual_en_o = (state_q == ST_IDLE) && !start_i;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: parametrised shift register with hold / shift-right /
// shift-left / parallel-load modes, optional rotate, serial outputs at both
// ends, and a burst engine that performs Count shifts from one Start pulse.
//   Clk, Rst        clock, asynchronous active-high reset
//   En, Mode        manual operation (only in IDLE, no Start)
//   SIL, SIR        serial inputs for right / left shifts
//   PD              parallel load data
//   Rot             rotate: wrap bit replaces SIL/SIR
//   Start,Dir,Count burst request, direction, length
//   Q, SOR, SOL     contents, LSB, MSB
//   Busy, Done      burst in progress, burst complete pulse
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic             SIL,
  input  logic             SIR,
  input  logic [WIDTH-1:0] PD,
  input  logic             Rot,
  input  logic             Start,
  input  logic             Dir,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic             Busy,
  output logic             Done
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             shift_en;
  logic             shift_dir;
  logic             manual_en;
  logic             in_right;
  logic             in_left;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] shl_val;

  usr_burst_ctrl #(
    .CNT_W(CNT_W)
  ) u_burst_ctrl (
    .clk_i       (Clk),
    .rst_i       (Rst),
    .start_i     (Start),
    .dir_i       (Dir),
    .count_i     (Count),
    .shift_en_o  (shift_en),
    .shift_dir_o (shift_dir),
    .manual_en_o (manual_en),
    .busy_o      (Busy),
    .done_o      (Done)
  );

  // Bit entering the vacated end: the opposite end when rotating.
  assign in_right = Rot ? q_q[0]       : SIL;
  assign in_left  = Rot ? q_q[WIDTH-1] : SIR;
  assign shr_val  = {in_right, q_q[WIDTH-1:1]};
  assign shl_val  = {q_q[WIDTH-2:0], in_left};

  always_comb begin
    q_d = q_q;
    if (shift_en) begin
      q_d = (shift_dir == DIR_LEFT) ? shl_val : shr_val;
    end else if (manual_en && En) begin
      case (mode_t'(Mode))
        MODE_SHR:  q_d = shr_val;
        MODE_SHL:  q_d = shl_val;
        MODE_LOAD: q_d = PD;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q   = q_q;
  assign SOR = q_q[0];
  assign SOL = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench: stimulus pushes expected {Q,Busy,Done} after each edge,
// a monitor pops and compares on the falling edge.
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             sil = 1'b0;
  logic             sir = 1'b0;
  logic [WIDTH-1:0] pd = '0;
  logic             rot = 1'b0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic [WIDTH-1:0] q;
  logic             sor, sol, busy, done;

  universal_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Rst(rst), .En(en), .Mode(mode), .SIL(sil), .SIR(sir),
    .PD(pd), .Rot(rot), .Start(start), .Dir(dir), .Count(count),
    .Q(q), .SOR(sor), .SOL(sol), .Busy(busy), .Done(done)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] exp_q_fifo[$];
  logic [1:0]       exp_bd_fifo[$];
  string            exp_name_fifo[$];
  int               checks = 0;
  int               errors = 0;

  task automatic push(input string name, input logic [WIDTH-1:0] eq,
                      input logic eb, input logic ed);
    exp_name_fifo.push_back(name);
    exp_q_fifo.push_back(eq);
    exp_bd_fifo.push_back({eb, ed});
  endtask

  // One clock edge with the current inputs, then record the expectation.
  task automatic tick(input string name, input logic [WIDTH-1:0] eq,
                      input logic eb, input logic ed);
    @(posedge clk);
    #1;
    push(name, eq, eb, ed);
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    en = 1'b1; mode = 2'b11; pd = v;
    tick("load", v, 1'b0, 1'b0);
    en = 1'b0; mode = 2'b00;
  endtask

  // Monitor: compare every pending expectation away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q_fifo.size() > 0) begin
        string            nm;
        logic [WIDTH-1:0] eq;
        logic [1:0]       bd;
        nm = exp_name_fifo.pop_front();
        eq = exp_q_fifo.pop_front();
        bd = exp_bd_fifo.pop_front();
        checks++;
        if (q !== eq || busy !== bd[1] || done !== bd[0] ||
            sor !== eq[0] || sol !== eq[WIDTH-1]) begin
          errors++;
          $display("FAIL %s: got Q=%h Busy=%b Done=%b SOR=%b SOL=%b, expected Q=%h Busy=%b Done=%b SOR=%b SOL=%b",
                   nm, q, busy, done, sor, sol, eq, bd[1], bd[0], eq[0], eq[WIDTH-1]);
        end else begin
          $display("ok   %s: Q=%h Busy=%b Done=%b", nm, q, busy, done);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [WIDTH-1:0] rot12 [12];

  initial begin
    // F0 rotated right by 1..12 positions.
    rot12 = '{8'h78, 8'h3C, 8'h1E, 8'h0F, 8'h87, 8'hC3,
              8'hE1, 8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h0F};

    // Reset state.
    tick("reset", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Load then shift right with SIL=1.
    load(8'hC3);
    en = 1'b1; mode = 2'b01; sil = 1'b1;
    tick("shr_sil1", 8'hE1, 1'b0, 1'b0);
    en = 1'b0; mode = 2'b00; sil = 1'b0;

    // Left shift with and without rotate.
    load(8'h81);
    en = 1'b1; mode = 2'b10; sir = 1'b0; rot = 1'b1;
    tick("shl_rot", 8'h03, 1'b0, 1'b0);
    rot = 1'b0;
    load(8'h81);
    en = 1'b1; mode = 2'b10;
    tick("shl_norot", 8'h02, 1'b0, 1'b0);

    // Burst left by 3; manual mode and Start requests ignored while busy.
    load(8'h01);
    start = 1'b1; dir = 1'b1; count = 4'd3; en = 1'b1; mode = 2'b11; pd = 8'hFF;
    tick("burst3_start", 8'h01, 1'b1, 1'b0);
    dir = 1'b0; count = 4'd5;
    tick("burst3_s1", 8'h02, 1'b1, 1'b0);
    tick("burst3_s2", 8'h04, 1'b1, 1'b0);
    start = 1'b0; en = 1'b0; mode = 2'b00;
    tick("burst3_s3_done", 8'h08, 1'b0, 1'b1);
    tick("burst3_after", 8'h08, 1'b0, 1'b0);

    // Zero-length burst.
    start = 1'b1; count = 4'd0;
    tick("count0_done", 8'h08, 1'b0, 1'b1);
    start = 1'b0;
    tick("count0_after", 8'h08, 1'b0, 1'b0);

    // Rotate right 12 times (more than WIDTH).
    load(8'hF0);
    start = 1'b1; dir = 1'b0; rot = 1'b1; count = 4'd12;
    tick("burst12_start", 8'hF0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick($sformatf("burst12_s%0d", i + 1), rot12[i], (i != 11), (i == 11));
    end
    // Re-Start in the Done cycle: left by 2, SIR=1, no rotate.
    start = 1'b1; dir = 1'b1; rot = 1'b0; sir = 1'b1; count = 4'd2;
    tick("restart_accept", 8'h0F, 1'b1, 1'b0);
    start = 1'b0;
    tick("restart_s1", 8'h1F, 1'b1, 1'b0);
    tick("restart_s2_done", 8'h3F, 1'b0, 1'b1);
    tick("restart_after", 8'h3F, 1'b0, 1'b0);
    sir = 1'b0;

    // Asynchronous reset mid-burst, between edges.
    load(8'hA5);
    start = 1'b1; dir = 1'b0; rot = 1'b1; count = 4'd5;
    tick("rstburst_start", 8'hA5, 1'b1, 1'b0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    push("async_reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick("post_reset_idle", 8'h00, 1'b0, 1'b0);
    rot = 1'b0;

    // Let the monitor drain the scoreboard, bounded.
    repeat (2) @(negedge clk);
    #1;
    if (exp_q_fifo.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q_fifo.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
